// File: rtl/fetch_stage_param.sv
// Instruction-fetch stage: PC register, next-PC select, on-chip instruction memory with a
// debug load path, run/single-step control, wrong-path squash, sticky halt and fetch counter.
module fetch_stage_param #(
    parameter int                DATA_W    = 32,
    parameter int                PC_W      = 32,
    parameter int                ADDR_W    = 8,
    parameter int                PC_INC    = 4,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_start,
    input  logic              i_step_mode,
    input  logic              i_step,
    input  logic              i_taken,
    input  logic [PC_W-1:0]   i_branch_address,
    input  logic              i_PC_write,
    output logic [PC_W-1:0]   o_pc,
    output logic [DATA_W-1:0] o_instruction,
    output logic              o_valid,
    output logic              os_stop_pipe,
    output logic [CNT_W-1:0]  o_fetch_count
);

    localparam logic [PC_W-1:0]  PC_STEP = PC_W'(PC_INC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STEP,
        S_HALT
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_seq;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;
    logic              adv;
    logic              live;
    logic              halt_hit;
    logic              load_exit;

    // Word index drops the byte offset; PC bits above the memory depth alias (wrap).
    assign rd_addr = pc[ADDR_W+1:2];
    assign rd_word = mem[rd_addr];
    assign pc_seq  = pc + PC_STEP;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a load request overrides everything, including HALT.
    always_comb begin
        state_nx = state;
        if (i_load_en) begin
            state_nx = S_LOAD;
        end else begin
            case (state)
                S_LOAD: state_nx = S_IDLE;
                S_IDLE: if (i_start) state_nx = i_step_mode ? S_STEP : S_RUN;
                S_RUN,
                S_STEP: if (halt_hit) state_nx = S_HALT;
                default: state_nx = state;
            endcase
        end
    end

    // Control outputs. Halt is decided from the word being read so that the state
    // and the sticky flag change on the same edge that delivers the halt word.
    always_comb begin
        adv       = 1'b0;
        load_exit = 1'b0;
        if (!i_load_en) begin
            case (state)
                S_RUN:   adv = i_PC_write;
                S_STEP:  adv = i_PC_write & i_step;
                S_LOAD:  load_exit = 1'b1;
                default: adv = 1'b0;
            endcase
        end
        live     = adv & ~i_taken;
        halt_hit = live & (rd_word == HALT_WORD);
    end

    // Program memory is not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (i_load_en) begin
            mem[i_load_addr] <= i_load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            o_pc          <= '0;
            o_instruction <= '0;
            o_valid       <= 1'b0;
            os_stop_pipe  <= 1'b0;
            o_fetch_count <= '0;
        end else begin
            o_valid <= live;
            if (load_exit) begin
                pc            <= RESET_PC;
                o_fetch_count <= '0;
                os_stop_pipe  <= 1'b0;
            end
            // A squashed fetch still updates the data outputs; only o_valid marks it dead.
            if (adv) begin
                o_instruction <= rd_word;
                o_pc          <= pc_seq;
                pc            <= i_taken ? i_branch_address : pc_seq;
            end
            if (live) begin
                o_fetch_count <= o_fetch_count + CNT_ONE;
            end
            if (halt_hit) begin
                os_stop_pipe <= 1'b1;
            end
        end
    end

endmodule
